// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
// FSM state encoding and its width.
package serial_add_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adders and an OR.
// The only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    ha u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    ha u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/ha.sv
// Half-adder: the basic two-input sum/carry gate pair.
// Building block of the full-adder cell.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH cycles.
// Operands in on a start handshake, sum out on a result handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;
    logic             last;

    fa_cell u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // New sum bit enters at the MSB so the LSB-first stream lands aligned.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nxt = s;
        end else begin : g_wn
            assign sum_nxt = {s, sum[WIDTH-1:1]};
        end
    endgenerate

    assign last        = (cnt == CW'(WIDTH - 1));
    assign start_ready = (state == IDLE);
    assign busy        = (state == RUN) || (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_valid) state_nxt = RUN;
            RUN:  if (last)        state_nxt = DONE;
            DONE: if (res_ready)   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa        <= '0;
            sb        <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        sa    <= op_a;
                        sb    <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= co;
                    sum   <= sum_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        res_sum   <= sum_nxt;
                        res_cout  <= co;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Expected sums are hand values or a plain a+b+cin model.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;

    logic       sv8, sr8, rv8, rr8, rc8, bz8, ci8;
    logic [7:0] a8, b8, rs8;

    logic       sv1, sr1, rv1, rr1, rc1, bz1, ci1;
    logic [0:0] a1, b1, rs1;

    int n_tests;
    int n_fail;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (sv8),
        .start_ready (sr8),
        .op_a        (a8),
        .op_b        (b8),
        .cin         (ci8),
        .res_valid   (rv8),
        .res_ready   (rr8),
        .res_sum     (rs8),
        .res_cout    (rc8),
        .busy        (bz8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (sv1),
        .start_ready (sr1),
        .op_a        (a1),
        .op_b        (b1),
        .cin         (ci1),
        .res_valid   (rv1),
        .res_ready   (rr1),
        .res_sum     (rs1),
        .res_cout    (rc1),
        .busy        (bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic hold,
                        input string tag);
        int n;
        int lat;
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
        a8 = a; b8 = b; ci8 = c; sv8 = 1'b1;
        n = 0;
        while (!sr8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!sr8) begin
            check({tag, " ready timeout"}, 64'(sr8), 64'd1);
            return;
        end
        @(posedge clk); #1;
        if (!hold) sv8 = 1'b0;
        lat = 0;
        while (!rv8 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " sum"}, 64'(rs8), 64'(exp[7:0]));
        check({tag, " cout"}, 64'(rc8), 64'(exp[8]));
    endtask

    task automatic add1(input logic a, input logic b, input logic c,
                        input string tag);
        int n;
        int lat;
        logic [1:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {1'b0, c};
        a1 = a; b1 = b; ci1 = c; sv1 = 1'b1;
        n = 0;
        while (!sr1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!sr1) begin
            check({tag, " ready timeout"}, 64'(sr1), 64'd1);
            return;
        end
        @(posedge clk); #1;
        lat = 0;
        while (!rv1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd1);
        check({tag, " sum"}, 64'(rs1), 64'(exp[0]));
        check({tag, " cout"}, 64'(rc1), 64'(exp[1]));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        sv8 = 1'b0; rr8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0;
        sv1 = 1'b0; rr1 = 1'b1; a1 = '0; b1 = '0; ci1 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(bz8), 64'd0);
        check("rst res_valid", 64'(rv8), 64'd0);
        check("rst res_sum", 64'(rs8), 64'd0);
        check("rst res_cout", 64'(rc8), 64'd0);
        check("rst start_ready", 64'(sr8), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        add8(8'h0F, 8'h01, 1'b0, 1'b0, "t1");
        check("t1 sum hand", 64'(rs8), 64'h10);
        add8(8'hFF, 8'h01, 1'b0, 1'b0, "t2");
        check("t2 cout hand", 64'(rc8), 64'd1);
        add8(8'hFF, 8'hFF, 1'b1, 1'b0, "t3a");
        check("t3a sum hand", 64'(rs8), 64'hFF);
        add8(8'h00, 8'h00, 1'b0, 1'b0, "t3b");
        check("t3b sum hand", 64'(rs8), 64'h00);

        // Hold off the consumer and poke start while DONE.
        @(posedge clk); #1;
        rr8 = 1'b0;
        add8(8'h3C, 8'h5A, 1'b1, 1'b0, "t4");
        for (int i = 0; i < 5; i++) begin
            sv8 = (i == 2);
            @(posedge clk); #1;
            check("t4 hold valid", 64'(rv8), 64'd1);
            check("t4 hold sum", 64'(rs8), 64'h97);
            check("t4 hold cout", 64'(rc8), 64'd0);
            check("t4 hold ready", 64'(sr8), 64'd0);
        end
        sv8 = 1'b0;
        rr8 = 1'b1;
        @(posedge clk); #1;
        check("t4 idle ready", 64'(sr8), 64'd1);
        check("t4 idle valid", 64'(rv8), 64'd0);
        check("t4 kept sum", 64'(rs8), 64'h97);
        @(posedge clk); #1;
        check("t4 no queue busy", 64'(bz8), 64'd0);

        // Abort mid-run.
        a8 = 8'h55; b8 = 8'h66; ci8 = 1'b1; sv8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("t5 pre busy", 64'(bz8), 64'd1);
        rst = 1'b1;
        #1;
        check("t5 rst busy", 64'(bz8), 64'd0);
        check("t5 rst valid", 64'(rv8), 64'd0);
        check("t5 rst sum", 64'(rs8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5 ready", 64'(sr8), 64'd1);
        add8(8'h22, 8'h11, 1'b0, 1'b0, "t5");
        check("t5 sum hand", 64'(rs8), 64'h33);

        // Back-to-back random stream, start_valid held high.
        for (int i = 0; i < 100; i++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "t6");
        end
        sv8 = 1'b0;

        add1(1'b0, 1'b0, 1'b0, "w1 000");
        add1(1'b1, 1'b1, 1'b1, "w1 111");
        check("w1 111 sum hand", 64'(rs1), 64'd1);
        for (int i = 0; i < 100; i++) begin
            add1(1'($urandom), 1'($urandom), 1'($urandom), "w1 rnd");
        end
        sv1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
